// File: rtl/uart_arbiter.sv
// uart_arbiter: shares one UART unit between two single-byte requesters.
// Grants one request at a time and runs the unit's go/done handshake.
// It routes completion and received data back to the owning port.
// Optional build macro: UART_ARB_FIXED_PRIO_EN. When it is defined, port 0
// always wins contention. When it is undefined, ports are served round-robin.
module uart_arbiter #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] rors,
    input  logic [7:0] txdata0,
    input  logic [7:0] txdata1,
    output logic [1:0] done,
    output logic [1:0] gnt,
    output logic [7:0] rxdata,
    output logic       u_go,
    output logic       u_rors,
    output logic [7:0] u_txdata,
    input  logic       u_done,
    input  logic [7:0] u_rxdata
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam bit GAP_EN = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GO   = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t        state;
    logic          owner;
    logic          win;
    logic [CW-1:0] gap_cnt;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic          last;
`endif

    // Winner of the current IDLE evaluation.
    always_comb begin
        win = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        if (req == 2'b11) begin
            win = ~last;
        end else begin
            win = req[1];
        end
`endif
    end

    // Arbiter FSM with registered outputs; grant latches direction and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            gap_cnt  <= '0;
            gnt      <= 2'b00;
            done     <= 2'b00;
            u_go     <= 1'b0;
            u_rors   <= 1'b0;
            u_txdata <= 8'h00;
            rxdata   <= 8'h00;
`ifndef UART_ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            done <= 2'b00;
            u_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= win;
                        gnt      <= win ? 2'b10 : 2'b01;
                        u_rors   <= rors[win];
                        u_txdata <= win ? txdata1 : txdata0;
                        u_go     <= 1'b1;
                        state    <= GO;
                    end
                end
                GO: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (u_done) begin
                        if (!u_rors) begin
                            rxdata <= u_rxdata;
                        end
                        done  <= owner ? 2'b10 : 2'b01;
                        state <= RESP;
                    end
                end
                RESP: begin
`ifndef UART_ARB_FIXED_PRIO_EN
                    last    <= owner;
`endif
                    gnt     <= 2'b00;
                    gap_cnt <= '0;
                    state   <= GAP_EN ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter. Instance dut uses GAP_CYCLES = 0 and
// instance dut_g uses GAP_CYCLES = 3.
module tb_uart_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, g_req, rors;
    logic [7:0] txdata0, txdata1, u_rxdata;
    logic       u_done, g_u_done;

    logic [1:0] done, gnt, g_done, g_gnt;
    logic [7:0] rxdata, u_txdata, g_rxdata, g_u_txdata;
    logic       u_go, u_rors, g_u_go, g_u_rors;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_arbiter #(.GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req(req), .rors(rors),
        .txdata0(txdata0), .txdata1(txdata1),
        .done(done), .gnt(gnt), .rxdata(rxdata),
        .u_go(u_go), .u_rors(u_rors), .u_txdata(u_txdata),
        .u_done(u_done), .u_rxdata(u_rxdata)
    );

    uart_arbiter #(.GAP_CYCLES(3)) dut_g (
        .clk(clk), .rst(rst), .req(g_req), .rors(rors),
        .txdata0(txdata0), .txdata1(txdata1),
        .done(g_done), .gnt(g_gnt), .rxdata(g_rxdata),
        .u_go(g_u_go), .u_rors(g_u_rors), .u_txdata(g_u_txdata),
        .u_done(g_u_done), .u_rxdata(u_rxdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the selected instance pulses u_go; n = cycles taken.
    task automatic wait_go(input string tag, input bit g, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            n++;
            seen = g ? g_u_go : u_go;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    logic [1:0] exp_own [3];
    int         n;

    initial begin
        rst = 1'b1; req = 2'b00; g_req = 2'b00; rors = 2'b00;
        txdata0 = 8'h00; txdata1 = 8'h00; u_rxdata = 8'h00;
        u_done = 1'b0; g_u_done = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_own[0] = 2'b01; exp_own[1] = 2'b01; exp_own[2] = 2'b01;
`else
        exp_own[0] = 2'b01; exp_own[1] = 2'b10; exp_own[2] = 2'b01;
`endif
        step(); step();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_u_go", 32'(u_go), 32'd0);
        check("rst_rxdata", 32'(rxdata), 32'd0);
        check("rst_u_txdata", 32'(u_txdata), 32'd0);

        // Port 0 sends 0x5A alone.
        req = 2'b01; rors = 2'b01; txdata0 = 8'h5A;
        step();
        check("send_gnt", 32'(gnt), 32'h1);
        check("send_u_go", 32'(u_go), 32'd1);
        check("send_u_txdata", 32'(u_txdata), 32'h5A);
        check("send_u_rors", 32'(u_rors), 32'd1);
        step();
        check("send_go_once", 32'(u_go), 32'd0);
        repeat (9) step();
        u_done = 1'b1; u_rxdata = 8'hEE;
        step();
        check("send_done", 32'(done), 32'h1);
        check("send_rxdata_kept", 32'(rxdata), 32'h0);
        u_done = 1'b0; req = 2'b00; u_rxdata = 8'h00;
        step();
        check("send_done_clear", 32'(done), 32'h0);
        check("send_gnt_clear", 32'(gnt), 32'h0);

        // Port 1 receives 0xC3.
        req = 2'b10; rors = 2'b00;
        step();
        check("recv_gnt", 32'(gnt), 32'h2);
        check("recv_u_go", 32'(u_go), 32'd1);
        check("recv_u_rors", 32'(u_rors), 32'd0);
        step();
        u_done = 1'b1; u_rxdata = 8'hC3;
        step();
        check("recv_done", 32'(done), 32'h2);
        check("recv_rxdata", 32'(rxdata), 32'hC3);
        u_done = 1'b0; req = 2'b00; u_rxdata = 8'h00;
        step();
        check("recv_idle_gnt", 32'(gnt), 32'h0);
        // u_done while idle must be ignored.
        u_done = 1'b1; u_rxdata = 8'h77;
        step();
        check("stray_done_rx", 32'(rxdata), 32'hC3);
        check("stray_done_out", 32'(done), 32'h0);
        check("stray_done_go", 32'(u_go), 32'd0);
        u_done = 1'b0; u_rxdata = 8'h00;

        // Owner changes txdata0 after grant.
        req = 2'b01; rors = 2'b01; txdata0 = 8'h11;
        step();
        check("hold_u_go", 32'(u_go), 32'd1);
        txdata0 = 8'h22;
        step(); step();
        check("hold_wait_txdata", 32'(u_txdata), 32'h11);
        u_done = 1'b1;
        step();
        check("hold_done", 32'(done), 32'h1);
        check("hold_done_txdata", 32'(u_txdata), 32'h11);
        u_done = 1'b0; req = 2'b00;
        step();

        // Reset during WAIT of a port 1 receive.
        req = 2'b10; rors = 2'b00;
        step(); step();
        check("prerst_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        step();
        check("wrst_gnt", 32'(gnt), 32'h0);
        check("wrst_u_go", 32'(u_go), 32'd0);
        check("wrst_rxdata", 32'(rxdata), 32'h0);
        check("wrst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Both requesting from reset, three rounds.
        req = 2'b11; rors = 2'b11; txdata0 = 8'hA0; txdata1 = 8'hB1;
        for (int r = 0; r < 3; r++) begin
            wait_go("rr_go_timeout", 1'b0, n);
            if (r == 0) check("rr_first_latency", 32'(n), 32'd1);
            else        check("rr_spacing", 32'(n), 32'd2);
            check("rr_gnt", 32'(gnt), 32'(exp_own[r]));
            check("rr_u_txdata", 32'(u_txdata), (exp_own[r] == 2'b01) ? 32'hA0 : 32'hB1);
            step();
            u_done = 1'b1;
            step();
            check("rr_done", 32'(done), 32'(exp_own[r]));
            u_done = 1'b0;
        end
        req = 2'b00;
        step(); step();

        // GAP_CYCLES = 3, back-to-back port 0 sends.
        g_req = 2'b01; rors = 2'b01; txdata0 = 8'h33;
        wait_go("gap_go_timeout", 1'b1, n);
        check("gap_u_txdata", 32'(g_u_txdata), 32'h33);
        step();
        g_u_done = 1'b1;
        step();
        check("gap_done", 32'(g_done), 32'h1);
        g_u_done = 1'b0;
        wait_go("gap_go2_timeout", 1'b1, n);
        check("gap_spacing", 32'(n), 32'd5);
        g_req = 2'b00;
        step();
        g_u_done = 1'b1;
        step();
        g_u_done = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
